// File: rtl/hazard_if.sv
// hazard_if: pipeline-side signal bundle between the CPU stages and the hazard unit.
interface hazard_if #(parameter int CNTW = 16);
  logic [4:0] RnID, RmID;
  logic useRmID, cbzID, bcondID;
  logic [4:0] RdEXout, RdMEMout;
  logic RegWriteEXout, MemReadEXout, MemReadMEMout, FlagSetEXout;
  logic memAccessMEM, dmem_ack;
  logic PCWrite, IFIDWrite, ctrlBubble, freeze, fault;
  logic [CNTW-1:0] stallCount, freezeCount;
  modport master (
    output RnID, RmID, useRmID, cbzID, bcondID, RdEXout, RdMEMout,
           RegWriteEXout, MemReadEXout, MemReadMEMout, FlagSetEXout,
           memAccessMEM, dmem_ack,
    input  PCWrite, IFIDWrite, ctrlBubble, freeze, fault, stallCount, freezeCount
  );
  modport slave (
    input  RnID, RmID, useRmID, cbzID, bcondID, RdEXout, RdMEMout,
           RegWriteEXout, MemReadEXout, MemReadMEMout, FlagSetEXout,
           memAccessMEM, dmem_ack,
    output PCWrite, IFIDWrite, ctrlBubble, freeze, fault, stallCount, freezeCount
  );
endinterface

// File: rtl/hazard_unit.sv
// hazard_unit: load-use/branch stall detection, memory-wait freeze with timeout fault,
// and saturating stall/freeze cycle counters.
module hazard_unit #(
  parameter int TIMEOUT = 64,
  parameter int CNTW = 16
) (
  input logic clk,
  input logic reset,
  hazard_if.slave hz
);
  typedef enum logic [1:0] {RUN, MEMWAIT, FAULT} state_t;
  state_t r_state, w_next;
  logic [15:0] r_wcnt;
  logic [CNTW-1:0] r_stall, r_freeze;
  logic w_ex_ok, w_mem_ok, w_need, w_freeze;
  // X31 is the zero register, so it never produces a dependency
  always_comb begin
    w_ex_ok = hz.RdEXout != 5'd31;
    w_mem_ok = hz.RdMEMout != 5'd31;
    w_need = (hz.MemReadEXout && w_ex_ok &&
              (hz.RdEXout == hz.RnID || (hz.useRmID && hz.RdEXout == hz.RmID))) ||
             (hz.cbzID && hz.RegWriteEXout && w_ex_ok && hz.RdEXout == hz.RmID) ||
             (hz.cbzID && hz.MemReadMEMout && w_mem_ok && hz.RdMEMout == hz.RmID) ||
             (hz.bcondID && hz.FlagSetEXout);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= RUN;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = (r_state == FAULT) ? FAULT :
             (r_state == MEMWAIT) ? (hz.dmem_ack ? RUN :
                                     (r_wcnt == 16'(TIMEOUT - 1) ? FAULT : MEMWAIT)) :
             ((hz.memAccessMEM && !hz.dmem_ack) ? MEMWAIT : RUN);
  end
  always_comb begin
    w_freeze = (r_state == FAULT) || (r_state == MEMWAIT && !hz.dmem_ack) ||
               (r_state == RUN && hz.memAccessMEM && !hz.dmem_ack);
    hz.freeze = w_freeze;
    hz.fault = r_state == FAULT;
    hz.PCWrite = !w_freeze && !w_need;
    hz.IFIDWrite = !w_freeze && !w_need;
    hz.ctrlBubble = !w_freeze && w_need;
    hz.stallCount = r_stall;
    hz.freezeCount = r_freeze;
  end
  // wait counter holds the number of freeze cycles already spent on this access
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wcnt <= '0;
      r_stall <= '0;
      r_freeze <= '0;
    end else begin
      r_wcnt <= (w_next == MEMWAIT) ? ((r_state == RUN) ? 16'd1 : r_wcnt + 16'd1) : '0;
      r_stall <= (!w_freeze && w_need && !(&r_stall)) ? r_stall + CNTW'(1) : r_stall;
      r_freeze <= (w_freeze && !(&r_freeze)) ? r_freeze + CNTW'(1) : r_freeze;
    end
  end
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed scenarios plus randomized traffic against a cycle-level model.
module tb_hazard_unit;
  localparam int TO = 4;
  localparam int CW = 8;
  localparam int MAXC = (1 << CW) - 1;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  hazard_if #(.CNTW(CW)) hz ();
  hazard_unit #(.TIMEOUT(TO), .CNTW(CW)) dut (.clk(clk), .reset(reset), .hz(hz));
  int checks = 0;
  int failures = 0;
  int m_waited, m_stall, m_freeze;
  bit m_fault, m_wait;
  bit e_need, e_freeze;
  logic [4:0] o, e_o;
  // model: the requirement rules straight from the hazard table
  always_comb begin
    e_need = (hz.MemReadEXout && hz.RdEXout != 31 &&
              (hz.RdEXout == hz.RnID || (hz.useRmID && hz.RdEXout == hz.RmID))) ||
             (hz.cbzID && hz.RegWriteEXout && hz.RdEXout != 31 && hz.RdEXout == hz.RmID) ||
             (hz.cbzID && hz.MemReadMEMout && hz.RdMEMout != 31 && hz.RdMEMout == hz.RmID) ||
             (hz.bcondID && hz.FlagSetEXout);
    e_freeze = m_fault || ((m_wait || hz.memAccessMEM) && !hz.dmem_ack);
    e_o = {!e_freeze && !e_need, !e_freeze && !e_need, !e_freeze && e_need, e_freeze, m_fault};
    o = {hz.PCWrite, hz.IFIDWrite, hz.ctrlBubble, hz.freeze, hz.fault};
  end
  task automatic model_clear;
    m_waited = 0; m_stall = 0; m_freeze = 0; m_fault = 0; m_wait = 0;
  endtask
  task automatic tick;
    @(posedge clk);
    if (!reset) model_clear();
    else begin
      if (e_freeze) m_freeze = (m_freeze < MAXC) ? m_freeze + 1 : MAXC;
      else if (e_need) m_stall = (m_stall < MAXC) ? m_stall + 1 : MAXC;
      if (!m_fault) begin
        if (e_freeze) begin
          m_waited++;
          m_wait = 1;
          if (m_waited >= TO) m_fault = 1;
        end else begin
          m_waited = 0;
          m_wait = 0;
        end
      end
    end
    #1;
  endtask
  task automatic idle;
    hz.RnID = 0; hz.RmID = 0; hz.useRmID = 0; hz.cbzID = 0; hz.bcondID = 0;
    hz.RdEXout = 0; hz.RdMEMout = 0; hz.RegWriteEXout = 0; hz.MemReadEXout = 0;
    hz.MemReadMEMout = 0; hz.FlagSetEXout = 0; hz.memAccessMEM = 0; hz.dmem_ack = 0;
  endtask
  task automatic apply_reset;
    reset = 0;
    idle();
    model_clear();
    tick();
    reset = 1;
  endtask
  task automatic test_reset;
    reset = 0;
    idle();
    #1;
    checks++;
    if (o !== 5'b11000 || hz.stallCount !== 0 || hz.freezeCount !== 0) begin
      failures++; $display("FAIL reset_idle outs=%b stall=%0d frz=%0d want 11000/0/0", o, hz.stallCount, hz.freezeCount);
    end
    hz.memAccessMEM = 1;
    #1;
    checks++;
    if (o !== 5'b00010) begin failures++; $display("FAIL reset_memwait outs=%b want 00010", o); end
    hz.memAccessMEM = 0;
    model_clear();
    tick();
    reset = 1;
  endtask
  task automatic test_load_use;
    apply_reset();
    hz.RdEXout = 2; hz.MemReadEXout = 1; hz.RegWriteEXout = 1; hz.RnID = 2;
    #3;
    checks++;
    if (o !== 5'b00100 || hz.stallCount !== 0) begin
      failures++; $display("FAIL load_use outs=%b stall=%0d want 00100/0", o, hz.stallCount);
    end
    tick();
    idle();
    #3;
    checks++;
    if (o !== 5'b11000 || hz.stallCount !== 1) begin
      failures++; $display("FAIL load_use_after outs=%b stall=%0d want 11000/1", o, hz.stallCount);
    end
  endtask
  task automatic test_cbz_load;
    apply_reset();
    hz.RdEXout = 5; hz.MemReadEXout = 1; hz.RegWriteEXout = 1; hz.cbzID = 1; hz.RmID = 5;
    #3;
    checks++;
    if (o !== 5'b00100) begin failures++; $display("FAIL cbz_ex outs=%b want 00100", o); end
    tick();
    hz.RdEXout = 0; hz.MemReadEXout = 0; hz.RegWriteEXout = 0;
    hz.RdMEMout = 5; hz.MemReadMEMout = 1;
    #3;
    checks++;
    if (o !== 5'b00100) begin failures++; $display("FAIL cbz_mem outs=%b want 00100", o); end
    tick();
    hz.RdMEMout = 0; hz.MemReadMEMout = 0;
    #3;
    checks++;
    if (o !== 5'b11000 || hz.stallCount !== 2) begin
      failures++; $display("FAIL cbz_done outs=%b stall=%0d want 11000/2", o, hz.stallCount);
    end
    hz.RdEXout = 5; hz.RegWriteEXout = 1;
    #1;
    checks++;
    if (o !== 5'b00100) begin failures++; $display("FAIL cbz_alu outs=%b want 00100", o); end
    idle();
  endtask
  task automatic test_x31_flags;
    apply_reset();
    hz.RdEXout = 31; hz.MemReadEXout = 1; hz.RegWriteEXout = 1; hz.RnID = 31; hz.RmID = 31;
    hz.useRmID = 1; hz.cbzID = 1; hz.RdMEMout = 31; hz.MemReadMEMout = 1;
    #3;
    checks++;
    if (o !== 5'b11000) begin failures++; $display("FAIL x31 outs=%b want 11000", o); end
    tick();
    idle();
    hz.bcondID = 1; hz.FlagSetEXout = 1;
    #3;
    checks++;
    if (o !== 5'b00100) begin failures++; $display("FAIL bcond outs=%b want 00100", o); end
    tick();
    idle();
    #3;
    checks++;
    if (hz.stallCount !== 1) begin failures++; $display("FAIL bcond_cnt got=%0d want 1", hz.stallCount); end
  endtask
  task automatic test_freeze;
    apply_reset();
    hz.memAccessMEM = 1; hz.dmem_ack = 1;
    #3;
    checks++;
    if (o !== 5'b11000) begin failures++; $display("FAIL ack_first outs=%b want 11000", o); end
    tick();
    hz.dmem_ack = 0; hz.RdEXout = 2; hz.MemReadEXout = 1; hz.RnID = 2;
    for (int i = 0; i < 3; i++) begin
      #3;
      checks++;
      if (o !== 5'b00010) begin failures++; $display("FAIL freeze_%0d outs=%b want 00010", i, o); end
      tick();
    end
    hz.dmem_ack = 1; hz.MemReadEXout = 0;
    #3;
    checks++;
    if (o !== 5'b11000) begin failures++; $display("FAIL ack_cycle outs=%b want 11000", o); end
    tick();
    idle();
    #3;
    checks++;
    if (hz.freezeCount !== 3 || hz.stallCount !== 0) begin
      failures++; $display("FAIL freeze_cnt frz=%0d stall=%0d want 3/0", hz.freezeCount, hz.stallCount);
    end
  endtask
  task automatic test_async_reset;
    apply_reset();
    hz.memAccessMEM = 1;
    #3;
    tick();
    hz.memAccessMEM = 0;
    #2;
    checks++;
    if (o !== 5'b00010) begin failures++; $display("FAIL memwait_hold outs=%b want 00010", o); end
    reset = 0;
    #1;
    checks++;
    if (o !== 5'b11000 || hz.freezeCount !== 0) begin
      failures++; $display("FAIL async_reset outs=%b frz=%0d want 11000/0", o, hz.freezeCount);
    end
    model_clear();
    tick();
    reset = 1;
  endtask
  task automatic test_timeout;
    apply_reset();
    hz.memAccessMEM = 1;
    for (int i = 0; i < TO; i++) begin
      #3;
      checks++;
      if (o !== 5'b00010) begin failures++; $display("FAIL wait_%0d outs=%b want 00010", i, o); end
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      hz.dmem_ack = (i >= 2);
      #3;
      checks++;
      if (o !== 5'b00011) begin failures++; $display("FAIL fault_%0d outs=%b want 00011", i, o); end
      tick();
    end
    hz.memAccessMEM = 0; hz.dmem_ack = 0;
    reset = 0;
    #1;
    checks++;
    if (o !== 5'b11000 || hz.freezeCount !== 0 || hz.stallCount !== 0) begin
      failures++; $display("FAIL fault_clear outs=%b frz=%0d stall=%0d want 11000/0/0", o, hz.freezeCount, hz.stallCount);
    end
    model_clear();
    tick();
    reset = 1;
  endtask
  task automatic test_saturation;
    apply_reset();
    hz.bcondID = 1; hz.FlagSetEXout = 1;
    for (int i = 0; i < (1 << CW) + 5; i++) tick();
    #3;
    checks++;
    if (hz.stallCount !== MAXC || o !== 5'b00100) begin
      failures++; $display("FAIL stall_sat cnt=%0d outs=%b want %0d/00100", hz.stallCount, o, MAXC);
    end
    idle();
    hz.memAccessMEM = 1;
    for (int i = 0; i < (1 << CW) + 10; i++) tick();
    #3;
    checks++;
    if (hz.freezeCount !== MAXC || hz.fault !== 1'b1) begin
      failures++; $display("FAIL freeze_sat cnt=%0d fault=%b want %0d/1", hz.freezeCount, hz.fault, MAXC);
    end
    apply_reset();
  endtask
  task automatic test_random;
    int bad = 0;
    apply_reset();
    for (int n = 0; n < 800; n++) begin
      hz.RnID = 5'($urandom_range(29, 31)); hz.RmID = 5'($urandom_range(29, 31));
      hz.RdEXout = 5'($urandom_range(29, 31)); hz.RdMEMout = 5'($urandom_range(29, 31));
      hz.useRmID = 1'($urandom); hz.cbzID = 1'($urandom); hz.bcondID = 1'($urandom);
      hz.RegWriteEXout = 1'($urandom); hz.MemReadEXout = 1'($urandom);
      hz.MemReadMEMout = 1'($urandom); hz.FlagSetEXout = 1'($urandom);
      hz.memAccessMEM = ($urandom_range(0, 2) == 0);
      hz.dmem_ack = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 60) == 0) begin
        reset = 0;
        model_clear();
      end
      #3;
      checks++;
      if (o !== e_o || hz.stallCount !== CW'(m_stall) || hz.freezeCount !== CW'(m_freeze)) begin
        failures++;
        if (bad++ < 10) $display("FAIL random_%0d outs=%b stall=%0d frz=%0d want %b/%0d/%0d",
                                 n, o, hz.stallCount, hz.freezeCount, e_o, m_stall, m_freeze);
      end
      tick();
      reset = 1;
    end
  endtask
  initial begin
    idle();
    model_clear();
    test_reset();
    test_load_use();
    test_cbz_load();
    test_x31_flags();
    test_freeze();
    test_async_reset();
    test_timeout();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hazard_unit.md
# hazard_unit

Hazard detection and pipeline-hold controller for the five-stage pipelined CPU. It sits beside the forwarding unit and handles every case that forwarding cannot resolve:
- it stalls IF/ID and injects an ID/EX bubble on load-use and branch-operand hazards;
- it freezes the whole pipeline while a data-memory access in MEM is waiting for its acknowledge.

A timeout watchdog on that handshake latches a sticky fault. Saturating counters record stall and freeze cycles for performance analysis.

## Interface
Parameters:
- TIMEOUT, 64: maximum wait cycles for dmem_ack before fault; legal range 2..65535.
- CNTW, 16: width of the stall and freeze counters.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; asserting it (0) clears all state immediately.
- RnID, RmID  in  5 each  source registers of the instruction in ID; RmID also carries the CBZ test register Rt.
- useRmID  in  1  the ID instruction reads RmID as an operand; this is the same qualifier used for forwarding port B.
- cbzID  in  1  the ID instruction is CBZ/CBNZ; the branch resolves in ID and reads RmID.
- bcondID  in  1  the ID instruction is B.cond; it reads the flags in ID.
- RdEXout, RdMEMout  in  5 each  destination registers in EX and MEM.
- RegWriteEXout, MemReadEXout, MemReadMEMout  in  1 each  control bits of the EX and MEM stages.
- FlagSetEXout  in  1  the instruction in EX updates NZCV.
- memAccessMEM  in  1  the instruction in MEM performs a load or a store.
- dmem_ack  in  1  data memory completes the current access this cycle.
- PCWrite, IFIDWrite  out  1 each  enables for the PC register and the IF/ID register.
- ctrlBubble  out  1  forces the ID/EX control fields to zero (NOP).
- freeze  out  1  holds PC, IF/ID, ID/EX, EX/MEM and MEM/WB; no writeback occurs.
- fault  out  1  sticky: the memory handshake timed out.
- stallCount, freezeCount  out  CNTW each  saturating cycle counters.

## Operation
- X31 never creates a hazard. Any comparison with Rd = 5'b11111 is false.
- Hazard requirement `need` is combinational and is the OR of these terms:
  - Load-use: MemReadEXout, with RdEXout == RnID, or (useRmID and RdEXout == RmID).
  - CBZ on EX writer: cbzID & RegWriteEXout & RdEXout == RmID. Any writer qualifies, load or ALU.
  - CBZ on MEM load: cbzID & MemReadMEMout & RdMEMout == RmID.
  - Flags: bcondID & FlagSetEXout.
- Memory-wait FSM has three states: RUN, MEMWAIT, FAULT.
  - RUN → MEMWAIT when memAccessMEM & !dmem_ack. The wait counter loads 1.
  - MEMWAIT → RUN when dmem_ack. Otherwise the wait counter increments. Reaching TIMEOUT without ack → FAULT.
  - FAULT is terminal until reset. fault = 1 and freeze = 1 permanently.
- freeze = (RUN & memAccessMEM & !dmem_ack) | (MEMWAIT & !dmem_ack) | FAULT.
  - In the ack cycle freeze = 0, so the pipeline advances at that edge.
- When freeze = 1:
  - PCWrite = 0, IFIDWrite = 0, ctrlBubble = 0. Everything holds, so no bubble is inserted.
  - freezeCount increments.
  - Freeze has priority over hazard stalls.
- When freeze = 0 and need = 1:
  - PCWrite = 0, IFIDWrite = 0, ctrlBubble = 1.
  - stallCount increments.
- Otherwise: PCWrite = 1, IFIDWrite = 1, ctrlBubble = 0.
- Counters saturate at all-ones and never wrap.
- CBZ behind a load needs two stall cycles. No internal counter produces this: the EX term fires in the first cycle, the MEM term in the second.

## Timing
- Reset values, with reset = 0: state RUN, wait counter 0, fault 0, stallCount 0, freezeCount 0. Combinational outputs then evaluate with RUN: freeze = memAccessMEM & !dmem_ack, and PCWrite/IFIDWrite = 1 when no hazard.
- Reset asserted mid-MEMWAIT or in FAULT returns the FSM to RUN asynchronously.
- Stall and freeze outputs are Mealy. They take effect in the same cycle as the triggering inputs, so the held registers do not load at the next edge.
- Handshake: dmem_ack is sampled every cycle in RUN and MEMWAIT.
  - An ack in the first MEM cycle causes zero freeze cycles.
  - An ack after k wait cycles gives exactly k freeze cycles.
  - Fault is entered at the edge where the wait counter would exceed TIMEOUT, i.e. after TIMEOUT freeze cycles with no ack.
- Simultaneous hazard and freeze: only freezeCount increments. The hazard is re-evaluated after the freeze ends.

## Test plan
- LDUR X2 in EX (RdEXout=2, MemReadEXout=1); ADD in ID with RnID=2 → PCWrite=0, IFIDWrite=0, ctrlBubble=1 for 1 cycle; stallCount 0→1.
- LDUR X5 in EX, CBZ X5 in ID (cbzID=1, RmID=5) → 2 consecutive stall cycles (EX term, then MEM term); stallCount=2.
- RdEXout=31, MemReadEXout=1, RnID=31 → no stall; SUBS in EX with B.cond in ID → 1 stall.
- memAccessMEM=1, dmem_ack low for 3 cycles, then high → freeze=1 for exactly 3 cycles, 0 in the ack cycle; freezeCount=3; a simultaneous load-use hazard in ID leaves ctrlBubble=0 and stallCount unchanged.
- TIMEOUT=4, ack never asserted → fault rises after 4 freeze cycles and stays 1; reset pulse low → fault=0, state RUN, counters 0.
- Force 2^CNTW+5 stall cycles → stallCount holds at all-ones.
